reg_file_2r1w: RTL

- 32-entry x 32-bit register file with two read ports and one write port, one clock.
- Each read port's 32:1 selection is built from the team's 32-bit 32:1 mux (MUX32_32x1); the write path is a 5-to-32 decoder driving per-register load enables.
- Sits between instruction decode and the ALU: it supplies operands (DATA_R1/DATA_R2) and accepts write-back (DATA_W).
- Read data is registered, so the pipeline sees exactly one cycle of read latency.

---
 rtl/reg_file_2r1w.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/reg_file_2r1w.sv
// 32x32 register file, two registered read ports, one write port, r0 hardwired to zero.
// Build option: define REG_FILE_BYPASS_EN to forward same-edge write data to the read ports.
module reg_file_2r1w #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    SP_INDEX   = 29,
    parameter logic [DATA_WIDTH-1:0] SP_RESET   = 32'h03FF_FFFF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [4:0]            ADDR_R1,
    input  logic [4:0]            ADDR_R2,
    input  logic [4:0]            ADDR_W,
    input  logic [DATA_WIDTH-1:0] DATA_W,
    output logic [DATA_WIDTH-1:0] DATA_R1,
    output logic [DATA_WIDTH-1:0] DATA_R2,
    output logic                  R_VALID
);
    localparam int NUM_REGS = 32;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] rf;
    logic [NUM_REGS-1:1]                 wr_en;
    logic [DATA_WIDTH-1:0]               sel_r1, sel_r2;
    logic [DATA_WIDTH-1:0]               rd1_nxt, rd2_nxt;
    logic                                vld_q;

    // 5-to-32 write decoder; entry 0 has no load enable at all
    always_comb begin
        wr_en = '0;
        for (int i = 1; i < NUM_REGS; i++)
            wr_en[i] = WRITE && (ADDR_W == 5'(i));
    end

    assign rf[0] = '0;

    genvar g;
    generate
        for (g = 1; g < NUM_REGS; g++) begin : g_reg
            reg_cell #(
                .W        (DATA_WIDTH),
                .RESET_VAL((g == SP_INDEX) ? SP_RESET : '0)
            ) u_cell (
                .clk (CLK),
                .rst (RST),
                .load(wr_en[g]),
                .d   (DATA_W),
                .q   (rf[g])
            );
        end
    endgenerate

    mux32_32x1 #(.W(DATA_WIDTH)) u_mux_r1 (
        .d  (rf),
        .sel(ADDR_R1),
        .y  (sel_r1)
    );

    mux32_32x1 #(.W(DATA_WIDTH)) u_mux_r2 (
        .d  (rf),
        .sel(ADDR_R2),
        .y  (sel_r2)
    );

`ifdef REG_FILE_BYPASS_EN
    logic fwd_r1, fwd_r2;

    // r0 never forwards: a write to index 0 is dropped, so reads of 0 stay 0
    assign fwd_r1  = WRITE && (ADDR_W != 5'd0) && (ADDR_R1 == ADDR_W);
    assign fwd_r2  = WRITE && (ADDR_W != 5'd0) && (ADDR_R2 == ADDR_W);
    assign rd1_nxt = fwd_r1 ? DATA_W : sel_r1;
    assign rd2_nxt = fwd_r2 ? DATA_W : sel_r2;
`else
    assign rd1_nxt = sel_r1;
    assign rd2_nxt = sel_r2;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            DATA_R1 <= '0;
            DATA_R2 <= '0;
            vld_q   <= 1'b0;
        end else begin
            vld_q <= READ;
            if (READ) begin
                DATA_R1 <= rd1_nxt;
                DATA_R2 <= rd2_nxt;
            end
        end
    end

    assign R_VALID = vld_q;

endmodule

// One storage register with load enable and per-instance reset value.
module reg_cell #(
    parameter int           W         = 32,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       q <= RESET_VAL;
        else if (load) q <= d;
    end
endmodule

// 32:1 mux as a five-level 2:1 tree; sel[0] picks within adjacent pairs.
module mux32_32x1 #(
    parameter int W = 32
) (
    input  logic [31:0][W-1:0] d,
    input  logic [4:0]         sel,
    output logic [W-1:0]       y
);
    logic [15:0][W-1:0] s4;
    logic [7:0][W-1:0]  s3;
    logic [3:0][W-1:0]  s2;
    logic [1:0][W-1:0]  s1;

    genvar i;
    generate
        for (i = 0; i < 16; i++) begin : g_l4
            assign s4[i] = sel[0] ? d[2*i+1] : d[2*i];
        end
        for (i = 0; i < 8; i++) begin : g_l3
            assign s3[i] = sel[1] ? s4[2*i+1] : s4[2*i];
        end
        for (i = 0; i < 4; i++) begin : g_l2
            assign s2[i] = sel[2] ? s3[2*i+1] : s3[2*i];
        end
        for (i = 0; i < 2; i++) begin : g_l1
            assign s1[i] = sel[3] ? s2[2*i+1] : s2[2*i];
        end
    endgenerate

    assign y = sel[4] ? s1[1] : s1[0];
endmodule
